tx_framer: RTL and testbench
============================

TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter BAUD_DIV, default 20833; CLK cycles per transmitted bit (2400 bit/s at 50 MHz).
REQ-002 Parameter PREAMBLE_BYTES, default 4; number of 0xAA preamble bytes, legal range 1..15.
REQ-003 Parameter SYNC_WORD, default 16'h2DD4; 16-bit sync pattern sent after the preamble.
REQ-004 CLK  input  1  single system clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 byte_in  input  8  payload byte from the host side.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_last  input  1  qualifies byte_in as the final payload byte of the frame.
REQ-009 byte_ready  output  1  the holding register can accept a byte this cycle.
REQ-010 DATA  output  1  serial bit stream to the modulator; bits are MSB first.
REQ-011 bit_strobe  output  1  one-cycle pulse on each cycle in which DATA takes a new bit.
REQ-012 busy  output  1  high whenever the FSM is outside IDLE.
REQ-013 frame_done  output  1  one-cycle pulse when the checksum's last bit period ends.
REQ-014 underrun  output  1  one-cycle pulse when a frame is aborted for missing payload.

Function
REQ-015 Byte transfer: a byte transfers on any cycle with byte_valid && byte_ready; byte_in and byte_last are captured into an 8+1-bit holding register.
REQ-016 byte_ready rule: byte_ready = holding register empty AND NOT (a byte with byte_last has been accepted in the current frame).
REQ-017 FSM states: IDLE, PREAMBLE, SYNC, PAYLOAD, CHECKSUM.
- IDLE -> PREAMBLE on the cycle after the first transfer.
REQ-018 Baud counter and bit timing:
- The baud counter is cleared on IDLE->PREAMBLE.
- The counter counts 0..BAUD_DIV-1 and wraps.
- The first bit appears on DATA on the first PREAMBLE cycle, with bit_strobe high.
- Every later bit appears on the cycle after the counter reaches BAUD_DIV-1, with bit_strobe high.
REQ-019 PREAMBLE sends PREAMBLE_BYTES x 8'hAA, then goes to SYNC.
- SYNC sends SYNC_WORD[15] first through SYNC_WORD[0], then goes to PAYLOAD.
REQ-020 Payload byte loading:
- At each payload byte boundary (the first PAYLOAD bit, and every 8th bit after it), the holding register moves into the shift register.
- The holding register is then empty, so byte_ready may rise on the next cycle.
REQ-021 The first accepted byte stays in the holding register through PREAMBLE and SYNC, so byte_ready stays low until the first PAYLOAD bit.
REQ-022 Checksum: the running checksum is the 8-bit XOR of all payload bytes in the frame, cleared on IDLE->PREAMBLE.
REQ-023 End of payload: when the byte just sent was flagged last, the next boundary goes to CHECKSUM.
- CHECKSUM sends the checksum MSB first.
- After its 8th bit period, frame_done pulses and the FSM returns to IDLE.
REQ-024 Underrun:
- Trigger: at a PAYLOAD byte boundary the holding register is empty and the last flag has not been seen.
- Response: underrun pulses, DATA = 0, FSM goes to IDLE, no checksum is sent, and no frame_done pulses.
REQ-025 Boundary transfer: a transfer on the exact boundary cycle is not seen at that boundary; the byte is held for the next boundary.
- Underrun still fires if the holding register was empty at the boundary cycle.
REQ-026 Outputs in IDLE: DATA = 0 and bit_strobe = 0.
- A new frame may start on the cycle after frame_done or underrun.
REQ-027 Every frame of N payload bytes is exactly 8*(PREAMBLE_BYTES + 2 + N + 1) bit periods long.

Reset
REQ-028 While reset is high on a clock edge, the block returns to IDLE; this holds in every state, including mid-frame.
REQ-029 Reset values:
- DATA = 0, bit_strobe = 0, busy = 0, frame_done = 0, underrun = 0.
- Holding register empty, byte_ready = 1 on the first cycle after reset is released.
- Baud counter, bit counter and checksum = 0.
REQ-030 Reset mid-frame produces neither frame_done nor underrun, and discards any held byte.

Verification (BAUD_DIV=4, PREAMBLE_BYTES=1, SYNC_WORD=16'h2DD4)
REQ-031 One-byte frame:
- Stimulus: send 0x49 with last=1.
- Response: DATA = AA, 2D, D4, 49, 49 (checksum), MSB first, 40 bits x 4 cycles.
- busy high 160 cycles; frame_done pulses once.
REQ-032 Three-byte frame:
- Stimulus: send 0x01, 0x02, 0x83 (last), each presented as soon as byte_ready rises.
- Response: checksum byte 0x80; frame is 56 bits; no underrun.
REQ-033 Underrun:
- Stimulus: send 0x10 (not last), then withhold byte_valid.
- Response: underrun pulses at the second payload boundary (bit 32, cycle 128); DATA = 0; busy falls.
REQ-034 Reset mid-SYNC:
- Stimulus: assert reset at cycle 50 of a frame.
- Response: next cycle all outputs are at reset values, byte_ready = 1; no frame_done; a new frame then transmits correctly.
REQ-035 Boundary race:
- Stimulus: second byte transferred exactly on the boundary cycle of the first payload byte's end.
- Response: underrun fires; after that, a later byte with last=1 starts a clean frame.
REQ-036 Back-pressure:
- Stimulus: hold byte_valid high with 0xFF while a frame is running.
- Response: at most one byte is accepted per payload byte period; no transfer occurs once last has been accepted.

Source files
------------

// File: rtl/tx_framer.sv
// Serial frame transmitter: preamble, sync word, host payload and XOR checksum,
// shifted out MSB first at one bit per BAUD_DIV clocks.
module tx_framer #(
  parameter int          BAUD_DIV       = 20833,
  parameter int          PREAMBLE_BYTES = 4,
  parameter logic [15:0] SYNC_WORD      = 16'h2DD4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       DATA,
  output logic       bit_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  localparam int             CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     PRE_LAST = 4'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]     PRE_BYTE = 8'hAA;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, CHECKSUM} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx, byte_idx;
  logic [15:0]   sh;
  logic [7:0]    csum, hold_data;
  logic          hold_last, hold_full, last_acc, sent_last;
  logic          xfer, tick, field_end, load_byte, do_ur, do_done;

  assign byte_ready = !hold_full && !last_acc;
  assign xfer       = byte_valid && byte_ready;
  assign busy       = (state != IDLE);
  assign DATA       = sh[15];
  assign tick       = busy && (cnt == CNT_MAX);
  // sync is a 16-bit field; every other field is one byte
  assign field_end  = tick && (bit_idx == ((state == SYNC) ? 4'd15 : 4'd7));

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    load_byte = 1'b0;
    do_ur     = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE:     if (xfer) state_d = PREAMBLE;
      PREAMBLE: if (field_end && byte_idx == PRE_LAST) state_d = SYNC;
      SYNC, PAYLOAD:
        if (field_end) begin
          if (state == PAYLOAD && sent_last) state_d = CHECKSUM;
          else if (hold_full) begin
            state_d   = PAYLOAD;
            load_byte = 1'b1;
          end else begin
            state_d = IDLE;
            do_ur   = 1'b1;
          end
        end
      CHECKSUM:
        if (field_end) begin
          state_d = IDLE;
          do_done = 1'b1;
        end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      sh         <= '0;
      csum       <= '0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      last_acc   <= 1'b0;
      sent_last  <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      frame_done <= do_done;
      underrun   <= do_ur;

      // an aborted frame also drops a byte that raced the boundary
      if (do_ur) begin
        hold_full <= 1'b0;
        last_acc  <= 1'b0;
      end else if (do_done) begin
        last_acc <= 1'b0;
      end else if (xfer) begin
        hold_full <= 1'b1;
        hold_data <= byte_in;
        hold_last <= byte_last;
        last_acc  <= byte_last;
      end else if (load_byte) begin
        hold_full <= 1'b0;
      end

      if (state == IDLE) begin
        if (xfer) begin
          cnt        <= '0;
          csum       <= '0;
          sh         <= {PRE_BYTE, 8'h00};
          bit_idx    <= '0;
          byte_idx   <= '0;
          sent_last  <= 1'b0;
          bit_strobe <= 1'b1;
        end
      end else if (!tick) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
        if (state_d == IDLE) begin
          sh       <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
        end else begin
          bit_strobe <= 1'b1;
          if (load_byte) begin
            sh        <= {hold_data, 8'h00};
            csum      <= csum ^ hold_data;
            sent_last <= hold_last;
            bit_idx   <= '0;
          end else if (state_d != state) begin
            sh      <= (state_d == SYNC) ? SYNC_WORD : {csum, 8'h00};
            bit_idx <= '0;
          end else if (field_end) begin
            sh       <= {PRE_BYTE, 8'h00};
            bit_idx  <= '0;
            byte_idx <= byte_idx + 4'd1;
          end else begin
            sh      <= sh << 1;
            bit_idx <= bit_idx + 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_framer.sv
// Directed and randomized frames checked against a byte-level model of the
// frame layout (preamble, sync, payload, XOR checksum) and bit timing rules.
module tb_tx_framer;
  localparam int          BD = 4;
  localparam int          PB = 1;
  localparam logic [15:0] SW = 16'h2DD4;

  logic       CLK = 1'b0, reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0, byte_last = 1'b0;
  logic       byte_ready, DATA, bit_strobe, busy, frame_done, underrun;

  tx_framer #(.BAUD_DIV(BD), .PREAMBLE_BYTES(PB), .SYNC_WORD(SW)) dut (
    .CLK(CLK), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .DATA(DATA),
    .bit_strobe(bit_strobe), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_errors = 0;

  // frame stimulus setup
  logic [7:0] pay[$];
  int         n_offer, race_cycle;
  bit         last_on_final, keep_valid;

  // observations of one frame
  logic got[$];
  int   xfer_rel[$];
  int   busy_cyc, n_done, n_ur, n_extra, timing_err, stab_err, idle_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int n, input bit lst, input bit keep, input int race);
    n_offer = n; last_on_final = lst; keep_valid = keep; race_cycle = race;
  endtask

  // Drives the payload as soon as the DUT takes it and records the serial output.
  task automatic run_frame(input string tag, input int budget);
    int   rel, last_s, sent, post;
    logic cur;
    bit   ended;
    rel = -1; last_s = 0; sent = 0; post = 0; cur = 1'b0; ended = 1'b0;
    busy_cyc = 0; n_done = 0; n_ur = 0; n_extra = 0;
    timing_err = 0; stab_err = 0; idle_err = 0;
    got.delete(); xfer_rel.delete();
    for (int c = 0; c < budget && post < 3; c++) begin
      @(negedge CLK);
      if (busy) begin
        rel++;
        busy_cyc++;
        if (bit_strobe) begin
          if (got.size() == 0 ? (rel != 0) : (rel - last_s != BD)) timing_err++;
          last_s = rel;
          cur = DATA;
          got.push_back(DATA);
        end else if (got.size() == 0 || DATA !== cur) begin
          stab_err++;
        end
      end else begin
        if (DATA !== 1'b0 || bit_strobe !== 1'b0) idle_err++;
        if (rel >= 0) ended = 1'b1;
      end
      if (frame_done) n_done++;
      if (underrun)   n_ur++;
      if (frame_done || underrun) ended = 1'b1;
      if (ended) post++;
      if (!ended && sent < n_offer && (sent == 0 || race_cycle < 0 || rel == race_cycle)) begin
        byte_valid = 1'b1; byte_in = pay[sent];
        byte_last = last_on_final && (sent == n_offer - 1);
      end else if (!ended && keep_valid) begin
        byte_valid = 1'b1; byte_in = 8'hFF; byte_last = 1'b0;
      end else begin
        byte_valid = 1'b0; byte_in = 8'h00; byte_last = 1'b0;
      end
      if (byte_valid && byte_ready) begin
        if (sent < n_offer) begin
          xfer_rel.push_back(rel);
          sent++;
        end else n_extra++;
      end
    end
    chk({tag, ".ended"}, 32'(ended), 32'd1);
    byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
  endtask

  // k = payload bytes that made it onto the line
  task automatic check_frame(input string tag, input int k, input bit expect_done);
    logic [7:0] exp_q[$];
    logic [7:0] cs, g;
    cs = 8'h00;
    for (int i = 0; i < PB; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(SW[15:8]);
    exp_q.push_back(SW[7:0]);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(pay[i]);
      cs = cs ^ pay[i];
    end
    if (expect_done) exp_q.push_back(cs);
    chk({tag, ".busy_cycles"}, busy_cyc, exp_q.size() * 8 * BD);
    chk({tag, ".bits"}, got.size(), exp_q.size() * 8);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 8'h00;
      for (int b = 0; b < 8; b++)
        g = {g[6:0], (i * 8 + b < got.size()) ? got[i * 8 + b] : 1'bx};
      chk($sformatf("%s.byte%0d", tag, i), g, exp_q[i]);
    end
    chk({tag, ".frame_done"}, n_done, 32'(expect_done));
    chk({tag, ".underrun"}, n_ur, 32'(!expect_done));
    chk({tag, ".strobe_timing"}, timing_err, 0);
    chk({tag, ".data_stable"}, stab_err, 0);
    chk({tag, ".idle_outputs"}, idle_err, 0);
    chk({tag, ".extra_xfer"}, n_extra, 0);
  endtask

  initial begin
    int n, cnt_busy, cnt_ev, min_gap;

    // reset state
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("rst.DATA", DATA, 0);
    chk("rst.bit_strobe", bit_strobe, 0);
    chk("rst.busy", busy, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.underrun", underrun, 0);
    chk("rst.byte_ready", byte_ready, 1);

    // one-byte frame
    pay = '{8'h49};
    setup(1, 1'b1, 1'b0, -1);
    run_frame("one", 1000);
    check_frame("one", 1, 1'b1);

    // three-byte frame, checksum 0x80
    pay = '{8'h01, 8'h02, 8'h83};
    setup(3, 1'b1, 1'b0, -1);
    run_frame("three", 1000);
    check_frame("three", 3, 1'b1);

    // underrun after one non-last byte
    pay = '{8'h10};
    setup(1, 1'b0, 1'b0, -1);
    run_frame("urun", 1000);
    check_frame("urun", 1, 1'b0);
    @(negedge CLK);
    chk("urun.ready_after", byte_ready, 1);

    // second byte arrives on the boundary cycle itself: too late
    pay = '{8'hA1, 8'hB2};
    setup(2, 1'b1, 1'b0, 8 * (PB + 3) * BD - 1);
    run_frame("race", 1000);
    check_frame("race", 1, 1'b0);
    chk("race.xfers", xfer_rel.size(), 2);
    pay = '{8'h3C};
    setup(1, 1'b1, 1'b0, -1);
    run_frame("race_next", 1000);
    check_frame("race_next", 1, 1'b1);

    // back-pressure: valid held high throughout
    pay = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    setup(4, 1'b1, 1'b1, -1);
    run_frame("bp", 1000);
    check_frame("bp", 4, 1'b1);
    min_gap = 1 << 30;
    for (int i = 2; i < xfer_rel.size(); i++)
      if (xfer_rel[i] - xfer_rel[i-1] < min_gap) min_gap = xfer_rel[i] - xfer_rel[i-1];
    chk("bp.one_per_period", 32'(min_gap >= 8 * BD), 1);

    // reset during SYNC
    @(negedge CLK);
    byte_valid = 1'b1; byte_in = 8'h5A; byte_last = 1'b1;
    @(negedge CLK);
    byte_valid = 1'b0; byte_last = 1'b0; byte_in = 8'h00;
    chk("mid.started", busy, 1);
    repeat (50) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("mid.DATA", DATA, 0);
    chk("mid.bit_strobe", bit_strobe, 0);
    chk("mid.busy", busy, 0);
    chk("mid.frame_done", frame_done, 0);
    chk("mid.underrun", underrun, 0);
    chk("mid.byte_ready", byte_ready, 1);
    reset = 1'b0;
    cnt_busy = 0; cnt_ev = 0;
    repeat (200) begin
      @(negedge CLK);
      if (busy) cnt_busy++;
      if (frame_done || underrun) cnt_ev++;
    end
    chk("mid.quiet_busy", cnt_busy, 0);
    chk("mid.quiet_events", cnt_ev, 0);
    pay = '{8'hC7, 8'h18};
    setup(2, 1'b1, 1'b0, -1);
    run_frame("mid_next", 1000);
    check_frame("mid_next", 2, 1'b1);

    // randomized payloads
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 5));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      setup(n, 1'b1, 1'b0, -1);
      run_frame($sformatf("rnd%0d", r), 1000);
      check_frame($sformatf("rnd%0d", r), n, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
